// File: rtl/driver_operation_pkg.sv
// Shared opcodes, FSM states and MDIO frame constants for the driver operation engine.
package driver_operation_pkg;

    localparam logic [7:0] OP_NOP        = 8'h00;
    localparam logic [7:0] OP_CTRL_WR    = 8'h01;
    localparam logic [7:0] OP_CTRL_RD    = 8'h02;
    localparam logic [7:0] OP_MDIO_WR    = 8'h03;
    localparam logic [7:0] OP_MDIO_RD    = 8'h04;
    localparam logic [7:0] OP_SGMII_STAT = 8'h05;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EXEC       = 2'd1,
        MDIO_SHIFT = 2'd2,
        DONE       = 2'd3
    } state_t;

    // Clause-22 frame fields
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_TA    = 2'b10;

    localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

    function automatic logic is_mdio_op(input logic [7:0] op);
        return (op == OP_MDIO_WR) || (op == OP_MDIO_RD);
    endfunction

endpackage

// File: rtl/driver_operation_engine_mdio_master.sv
// Clause-22 MDIO master: shifts one frame per start, MSB first, one bit per MDC period.
// mdio_o is updated on the cycle MDC falls; mdio_i is sampled on the cycle MDC rises.
module mdio_master
    import driver_operation_pkg::*;
#(
    parameter int MDC_HALF     = 4,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_read,
    input  logic [4:0]  phy,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wdata,
    input  logic        mdio_i,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_t
);

    localparam int FRAME_LEN = PREAMBLE_LEN + 32;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);
    localparam int DIV_W     = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] PRE_END  = CNT_W'(PREAMBLE_LEN);
    localparam logic [CNT_W-1:0] TA_BIT   = CNT_W'(PREAMBLE_LEN + 14);
    localparam logic [CNT_W-1:0] DATA_BIT = CNT_W'(PREAMBLE_LEN + 16);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MDC_HALF - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] next_bit;
    logic [31:0]      payload;
    logic             read_q;
    logic             half_end;

    assign half_end = (div_cnt == DIV_LAST);
    assign next_bit = bit_cnt + CNT_W'(1);

    // Frame sequencer: MDC divider, bit counter, payload shifter and read capture.
    // The preamble is generated from the bit counter; payload holds ST..data (32 bits).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            payload <= '0;
            read_q  <= 1'b0;
            rdata   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            mdc     <= 1'b0;
            mdio_o  <= 1'b1;
            mdio_t  <= 1'b1;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy    <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    mdc     <= 1'b0;
                    read_q  <= is_read;
                    rdata   <= '0;
                    payload <= {MDIO_ST, (is_read ? MDIO_OP_RD : MDIO_OP_WR),
                                phy, reg_addr, MDIO_TA, wdata};
                    mdio_o  <= 1'b1;
                    mdio_t  <= 1'b0;
                end
            end else if (half_end) begin
                div_cnt <= '0;
                mdc     <= ~mdc;
                if (!mdc) begin
                    // MDC rising: capture read data bits
                    if (read_q && (bit_cnt >= DATA_BIT)) begin
                        rdata <= {rdata[14:0], mdio_i};
                    end
                end else if (bit_cnt == LAST_BIT) begin
                    // MDC falling after the last bit: release the line
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    mdio_o <= 1'b1;
                    mdio_t <= 1'b1;
                end else begin
                    // MDC falling: present the next bit
                    bit_cnt <= next_bit;
                    if (next_bit < PRE_END) begin
                        mdio_o <= 1'b1;
                    end else begin
                        mdio_o  <= payload[31];
                        payload <= {payload[30:0], 1'b0};
                    end
                    mdio_t <= read_q && (next_bit >= TA_BIT);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/driver_operation_engine.sv
// Command engine: one operation per start (control register, MDIO, SGMII status),
// result returned with a one-cycle done pulse. SGMII status logic is free-running.
module driver_operation_engine
    import driver_operation_pkg::*;
#(
    parameter int MDC_HALF     = 4,
    parameter int PREAMBLE_LEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    output logic        done_port,
    output logic [31:0] return_port,
    input  logic [7:0]  operation,
    input  logic [31:0] address,
    input  logic [31:0] value,
    output logic        sgmii_tx_p,
    output logic        sgmii_tx_n,
    input  logic        sgmii_rx_p,
    input  logic        sgmii_rx_n,
    input  logic        sgmii_clk_p,
    input  logic        sgmii_clk_n,
    input  logic        eth_mdio_i,
    output logic        eth_mdio_o,
    output logic        eth_mdio_t,
    output logic        eth_mdc,
    output logic        eth_reset_n
);

    state_t      state;
    state_t      next_state;
    logic [7:0]  op_q;
    logic [9:0]  addr_q;
    logic [31:0] value_q;
    logic [31:0] ctrl;
    logic [31:0] reg_result;
    logic        mdio_start;
    logic        mdio_busy;
    logic        mdio_done;
    logic [15:0] mdio_rdata;
    logic        op_is_read;

    logic        rx_p_meta;
    logic        rx_p_sync;
    logic        rx_p_prev;
    logic        clk_p_meta;
    logic        clk_p_sync;
    logic        rx_valid_meta;
    logic        rx_valid;
    logic [15:0] rx_toggle_cnt;
    logic [31:0] sgmii_stat;

    // Only the PHY/REG fields of the address matter; the N leg of the clock is not used.
    logic        unused_inputs;
    assign unused_inputs = ^{sgmii_clk_n, address[31:10], mdio_busy};

    assign sgmii_tx_p  = 1'b0;
    assign sgmii_tx_n  = 1'b1;
    assign eth_reset_n = ctrl[0];
    assign op_is_read  = (op_q == OP_MDIO_RD);
    assign sgmii_stat  = {rx_toggle_cnt, 13'b0, rx_p_sync, clk_p_sync, rx_valid};

    mdio_master #(
        .MDC_HALF     (MDC_HALF),
        .PREAMBLE_LEN (PREAMBLE_LEN)
    ) u_mdio (
        .clock    (clock),
        .reset    (reset),
        .start    (mdio_start),
        .is_read  (op_is_read),
        .phy      (addr_q[9:5]),
        .reg_addr (addr_q[4:0]),
        .wdata    (value_q[15:0]),
        .mdio_i   (eth_mdio_i),
        .rdata    (mdio_rdata),
        .busy     (mdio_busy),
        .done     (mdio_done),
        .mdc      (eth_mdc),
        .mdio_o   (eth_mdio_o),
        .mdio_t   (eth_mdio_t)
    );

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, done pulse and MDIO frame launch.
    always_comb begin
        next_state = state;
        done_port  = 1'b0;
        mdio_start = 1'b0;
        case (state)
            IDLE: begin
                if (start_port) next_state = EXEC;
            end
            EXEC: begin
                if (is_mdio_op(op_q)) begin
                    mdio_start = 1'b1;
                    next_state = MDIO_SHIFT;
                end else begin
                    next_state = DONE;
                end
            end
            MDIO_SHIFT: begin
                if (mdio_done) next_state = DONE;
            end
            DONE: begin
                done_port  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Result of the register/status opcodes, evaluated in EXEC.
    always_comb begin
        reg_result = ERR_RESULT;
        case (op_q)
            OP_NOP:        reg_result = 32'h0;
            OP_CTRL_WR:    reg_result = 32'h0;
            OP_CTRL_RD:    reg_result = ctrl;
            OP_MDIO_WR:    reg_result = 32'h0;
            OP_MDIO_RD:    reg_result = 32'h0;
            OP_SGMII_STAT: reg_result = sgmii_stat;
            default:       reg_result = ERR_RESULT;
        endcase
    end

    // Operand latch, control register and result register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_q        <= '0;
            addr_q      <= '0;
            value_q     <= '0;
            ctrl        <= '0;
            return_port <= '0;
        end else begin
            if ((state == IDLE) && start_port) begin
                op_q    <= operation;
                addr_q  <= address[9:0];
                value_q <= value;
            end
            if ((state == EXEC) && !is_mdio_op(op_q)) begin
                return_port <= reg_result;
                if (op_q == OP_CTRL_WR) ctrl <= value_q;
            end
            if ((state == MDIO_SHIFT) && mdio_done) begin
                return_port <= op_is_read ? {16'h0, mdio_rdata} : 32'h0;
            end
        end
    end

    // SGMII line status: 2-FF synchronisers and rx_p edge counter, independent of the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_p_meta     <= 1'b0;
            rx_p_sync     <= 1'b0;
            rx_p_prev     <= 1'b0;
            clk_p_meta    <= 1'b0;
            clk_p_sync    <= 1'b0;
            rx_valid_meta <= 1'b0;
            rx_valid      <= 1'b0;
            rx_toggle_cnt <= '0;
        end else begin
            rx_p_meta     <= sgmii_rx_p;
            rx_p_sync     <= rx_p_meta;
            rx_p_prev     <= rx_p_sync;
            clk_p_meta    <= sgmii_clk_p;
            clk_p_sync    <= clk_p_meta;
            rx_valid_meta <= sgmii_rx_p ^ sgmii_rx_n;
            rx_valid      <= rx_valid_meta;
            if (rx_p_sync != rx_p_prev) rx_toggle_cnt <= rx_toggle_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_driver_operation_engine.sv
// Self-checking bench for driver_operation_engine with a PHY/MDIO monitor and a reference model.
module tb_driver_operation_engine;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_port = 1'b0;
    logic        done_port;
    logic [31:0] return_port;
    logic [7:0]  operation = 8'h00;
    logic [31:0] address = 32'h0;
    logic [31:0] value = 32'h0;
    logic        sgmii_tx_p, sgmii_tx_n;
    logic        sgmii_rx_p = 1'b0;
    logic        sgmii_rx_n = 1'b1;
    logic        sgmii_clk_p = 1'b1;
    logic        sgmii_clk_n = 1'b0;
    logic        eth_mdio_i = 1'b1;
    logic        eth_mdio_o, eth_mdio_t, eth_mdc, eth_reset_n;

    int tests_run = 0;
    int fails = 0;

    // reference model state
    logic [31:0] m_ctrl = 32'h0;
    logic [15:0] m_toggles = 16'h0;

    // MDIO bus monitor / PHY model
    int          mdc_edges = 0;
    int          frame_base = 0;
    logic        cap_o [0:127];
    logic        cap_t [0:127];
    logic [15:0] phy_rdata = 16'h0;

    driver_operation_engine dut (
        .clock       (clock),
        .reset       (reset),
        .start_port  (start_port),
        .done_port   (done_port),
        .return_port (return_port),
        .operation   (operation),
        .address     (address),
        .value       (value),
        .sgmii_tx_p  (sgmii_tx_p),
        .sgmii_tx_n  (sgmii_tx_n),
        .sgmii_rx_p  (sgmii_rx_p),
        .sgmii_rx_n  (sgmii_rx_n),
        .sgmii_clk_p (sgmii_clk_p),
        .sgmii_clk_n (sgmii_clk_n),
        .eth_mdio_i  (eth_mdio_i),
        .eth_mdio_o  (eth_mdio_o),
        .eth_mdio_t  (eth_mdio_t),
        .eth_mdc     (eth_mdc),
        .eth_reset_n (eth_reset_n)
    );

    always #5 clock = ~clock;

    // Record each bit on MDC rise and present the PHY's read data for the next bit.
    always @(posedge eth_mdc) begin
        int idx;
        idx = mdc_edges - frame_base;
        if (idx >= 0 && idx < 128) begin
            cap_o[idx] = eth_mdio_o;
            cap_t[idx] = eth_mdio_t;
        end
        mdc_edges = mdc_edges + 1;
        if ((idx + 1) >= 48 && (idx + 1) < 64) eth_mdio_i = phy_rdata[63 - (idx + 1)];
        else eth_mdio_i = 1'b1;
    end

    function automatic logic [63:0] exp_frame(input bit rd, input logic [4:0] ph,
                                              input logic [4:0] rg, input logic [15:0] d);
        return {32'hFFFF_FFFF, 2'b01, (rd ? 2'b10 : 2'b01), ph, rg, 2'b10, d};
    endfunction

    function automatic logic [63:0] got_frame();
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[63 - i] = cap_o[i];
        return v;
    endfunction

    function automatic logic [63:0] got_tris();
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[63 - i] = cap_t[i];
        return v;
    endfunction

    task automatic run_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] v,
                          input int budget, output bit ok, output int lat,
                          output logic [31:0] res, output logic done_after);
        @(negedge clock);
        operation  = o;
        address    = a;
        value      = v;
        start_port = 1'b1;
        frame_base = mdc_edges;
        @(negedge clock);
        start_port = 1'b0;
        operation  = 8'($urandom);
        address    = $urandom;
        value      = $urandom;
        ok = 1'b0; lat = 1; res = 32'h0; done_after = 1'b0;
        while (lat <= budget) begin
            if (done_port === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
            lat++;
        end
        if (ok) begin
            res = return_port;
            @(negedge clock);
            done_after = done_port;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        tests_run++; if (done_port !== 1'b0) begin fails++; $display("FAIL reset_done: got %b, expected 0", done_port); end
        tests_run++; if (return_port !== 32'h0) begin fails++; $display("FAIL reset_return: got %h, expected 0", return_port); end
        tests_run++; if (eth_mdc !== 1'b0) begin fails++; $display("FAIL reset_mdc: got %b, expected 0", eth_mdc); end
        tests_run++; if (eth_mdio_o !== 1'b1) begin fails++; $display("FAIL reset_mdio_o: got %b, expected 1", eth_mdio_o); end
        tests_run++; if (eth_mdio_t !== 1'b1) begin fails++; $display("FAIL reset_mdio_t: got %b, expected 1", eth_mdio_t); end
        tests_run++; if (eth_reset_n !== 1'b0) begin fails++; $display("FAIL reset_phy_rst: got %b, expected 0", eth_reset_n); end
        tests_run++; if ({sgmii_tx_p, sgmii_tx_n} !== 2'b01) begin fails++; $display("FAIL reset_tx: got %b, expected 01", {sgmii_tx_p, sgmii_tx_n}); end
        #10 reset = 1'b0;
    endtask

    task automatic test_ctrl();
        bit ok; int lat; logic [31:0] res; logic da;
        run_op(8'h01, 32'h0, 32'h1, 20, ok, lat, res, da);
        m_ctrl = 32'h1;
        tests_run++; if (!ok) begin fails++; $display("FAIL ctrl_wr_done: no done within 20 cycles"); end
        tests_run++; if (lat !== 2) begin fails++; $display("FAIL ctrl_wr_latency: got %0d, expected 2", lat); end
        tests_run++; if (res !== 32'h0) begin fails++; $display("FAIL ctrl_wr_return: got %h, expected 0", res); end
        tests_run++; if (da !== 1'b0) begin fails++; $display("FAIL ctrl_wr_pulse: done still %b next cycle, expected 0", da); end
        tests_run++; if (eth_reset_n !== 1'b1) begin fails++; $display("FAIL ctrl_phy_rst: got %b, expected 1", eth_reset_n); end
        run_op(8'h02, 32'h0, 32'h0, 20, ok, lat, res, da);
        tests_run++; if (!ok || res !== m_ctrl) begin fails++; $display("FAIL ctrl_rd: got %h ok=%b, expected %h", res, ok, m_ctrl); end
        tests_run++; if (lat !== 2 || da !== 1'b0) begin fails++; $display("FAIL ctrl_rd_timing: latency %0d pulse-after %b, expected 2 and 0", lat, da); end
        repeat (3) @(negedge clock);
        tests_run++; if (return_port !== m_ctrl) begin fails++; $display("FAIL ctrl_rd_hold: got %h, expected %h", return_port, m_ctrl); end
    endtask

    task automatic test_mdio_write();
        bit ok; int lat; logic [31:0] res; logic da;
        run_op(8'h03, 32'h0000_0021, 32'h0000_ABCD, 2000, ok, lat, res, da);
        tests_run++; if (!ok || res !== 32'h0) begin fails++; $display("FAIL mdio_wr_return: got %h ok=%b, expected 0", res, ok); end
        tests_run++; if (mdc_edges - frame_base !== 64) begin fails++; $display("FAIL mdio_wr_periods: got %0d, expected 64", mdc_edges - frame_base); end
        tests_run++; if (got_frame() !== exp_frame(1'b0, 5'd1, 5'd1, 16'hABCD)) begin fails++; $display("FAIL mdio_wr_bits: got %h, expected %h", got_frame(), exp_frame(1'b0, 5'd1, 5'd1, 16'hABCD)); end
        tests_run++; if (got_tris() !== 64'h0) begin fails++; $display("FAIL mdio_wr_tristate: got %h, expected 0", got_tris()); end
        tests_run++; if ({eth_mdc, eth_mdio_o, eth_mdio_t} !== 3'b011) begin fails++; $display("FAIL mdio_wr_idle: mdc/o/t got %b, expected 011", {eth_mdc, eth_mdio_o, eth_mdio_t}); end
    endtask

    task automatic test_mdio_read();
        bit ok; int lat; logic [31:0] res; logic da;
        phy_rdata = 16'h1234;
        run_op(8'h04, 32'h0000_0022, 32'h0, 2000, ok, lat, res, da);
        tests_run++; if (!ok || res !== 32'h0000_1234) begin fails++; $display("FAIL mdio_rd_return: got %h ok=%b, expected 00001234", res, ok); end
        tests_run++; if (got_frame() >> 18 !== exp_frame(1'b1, 5'd1, 5'd2, 16'h0) >> 18) begin fails++; $display("FAIL mdio_rd_header: got %h, expected %h", got_frame() >> 18, exp_frame(1'b1, 5'd1, 5'd2, 16'h0) >> 18); end
        tests_run++; if (got_tris() !== 64'h3FFFF) begin fails++; $display("FAIL mdio_rd_tristate: got %h, expected 3ffff", got_tris()); end
    endtask

    task automatic test_sgmii();
        bit ok; int lat; logic [31:0] res; logic da; logic [31:0] expv;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            sgmii_rx_p = ~sgmii_rx_p;
            sgmii_rx_n = ~sgmii_rx_p;
            m_toggles++;
            repeat (2) @(negedge clock);
        end
        repeat (6) @(negedge clock);
        expv = {m_toggles, 13'b0, sgmii_rx_p, sgmii_clk_p, sgmii_rx_p ^ sgmii_rx_n};
        run_op(8'h05, 32'h0, 32'h0, 20, ok, lat, res, da);
        tests_run++; if (!ok || res !== expv) begin fails++; $display("FAIL sgmii_stat: got %h ok=%b, expected %h", res, ok, expv); end
        tests_run++; if (res[31:16] !== 16'd10 || res[0] !== 1'b1) begin fails++; $display("FAIL sgmii_count_valid: got count %0d valid %b, expected 10 and 1", res[31:16], res[0]); end
        @(negedge clock);
        sgmii_rx_n = sgmii_rx_p;
        repeat (6) @(negedge clock);
        run_op(8'h05, 32'h0, 32'h0, 20, ok, lat, res, da);
        tests_run++; if (!ok || res[0] !== 1'b0 || res[31:16] !== m_toggles) begin fails++; $display("FAIL sgmii_invalid: got %h ok=%b, expected bit0=0 count=%0d", res, ok, m_toggles); end
    endtask

    task automatic test_error();
        bit ok; int lat; logic [31:0] res; logic da;
        run_op(8'h7F, 32'h1234_5678, 32'h9ABC_DEF0, 20, ok, lat, res, da);
        tests_run++; if (!ok || res !== 32'hFFFF_FFFF) begin fails++; $display("FAIL bad_opcode: got %h ok=%b, expected ffffffff", res, ok); end
    endtask

    task automatic test_ignored_start();
        bit ok; int lat; logic [31:0] res; logic da; int dones;
        logic [31:0] frame_res;
        frame_res = 32'hFFFF_FFFF;
        @(negedge clock);
        operation = 8'h03; address = 32'h0000_0063; value = 32'h0000_1111; start_port = 1'b1;
        frame_base = mdc_edges;
        @(negedge clock);
        start_port = 1'b0;
        dones = 0;
        for (int i = 0; i < 800; i++) begin
            if (i == 60) begin
                operation = 8'h01; value = 32'h0000_DEAD; start_port = 1'b1;
            end else if (i == 61) begin
                start_port = 1'b0;
            end
            if (done_port === 1'b1) begin
                dones++;
                frame_res = return_port;
            end
            @(negedge clock);
        end
        tests_run++; if (dones !== 1) begin fails++; $display("FAIL ignored_start_dones: got %0d, expected 1", dones); end
        tests_run++; if (frame_res !== 32'h0) begin fails++; $display("FAIL ignored_start_return: got %h, expected 0", frame_res); end
        tests_run++; if (got_frame() !== exp_frame(1'b0, 5'd3, 5'd3, 16'h1111)) begin fails++; $display("FAIL ignored_start_bits: got %h, expected %h", got_frame(), exp_frame(1'b0, 5'd3, 5'd3, 16'h1111)); end
        run_op(8'h02, 32'h0, 32'h0, 20, ok, lat, res, da);
        tests_run++; if (!ok || res !== m_ctrl) begin fails++; $display("FAIL ignored_start_ctrl: got %h ok=%b, expected %h", res, ok, m_ctrl); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int lat; logic [31:0] res; logic da; bit hit;
        @(negedge clock);
        operation = 8'h03; address = 32'h0000_0021; value = 32'h0000_5555; start_port = 1'b1;
        frame_base = mdc_edges;
        @(negedge clock);
        start_port = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (eth_mdc === 1'b1 && (mdc_edges - frame_base) >= 5) begin
                hit = 1'b1;
                break;
            end
            @(negedge clock);
        end
        tests_run++; if (!hit) begin fails++; $display("FAIL midframe_mdc_high: MDC never high within 500 cycles"); end
        reset = 1'b1;
        #1;
        tests_run++; if ({eth_mdc, eth_mdio_o, eth_mdio_t, done_port} !== 4'b0110) begin fails++; $display("FAIL midframe_abort: mdc/o/t/done got %b, expected 0110", {eth_mdc, eth_mdio_o, eth_mdio_t, done_port}); end
        tests_run++; if (eth_reset_n !== 1'b0) begin fails++; $display("FAIL midframe_phy_rst: got %b, expected 0", eth_reset_n); end
        m_ctrl = 32'h0;
        m_toggles = 16'h0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        phy_rdata = 16'h5A5A;
        run_op(8'h04, 32'h0000_0045, 32'h0, 2000, ok, lat, res, da);
        tests_run++; if (!ok || res !== 32'h0000_5A5A) begin fails++; $display("FAIL midframe_next_op: got %h ok=%b, expected 00005a5a", res, ok); end
        tests_run++; if (mdc_edges - frame_base !== 64) begin fails++; $display("FAIL midframe_next_periods: got %0d, expected 64", mdc_edges - frame_base); end
    endtask

    task automatic test_random();
        bit ok; int lat; logic [31:0] res; logic da;
        logic [7:0] o; logic [31:0] a, v, expv; int sel; int budget; bit is_mdio;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            a = $urandom; v = $urandom;
            budget = 20; is_mdio = 1'b0;
            case (sel)
                0, 9: begin o = 8'h00; expv = 32'h0; end
                1, 2: begin o = 8'h01; expv = 32'h0; end
                3:    begin o = 8'h02; expv = m_ctrl; end
                4:    begin o = 8'($urandom_range(6, 255)); expv = 32'hFFFF_FFFF; end
                5, 6: begin
                    o = 8'h05;
                    for (int k = $urandom_range(0, 5); k > 0; k--) begin
                        @(negedge clock);
                        sgmii_rx_p = ~sgmii_rx_p;
                        m_toggles++;
                        repeat (2) @(negedge clock);
                    end
                    sgmii_rx_n = 1'($urandom);
                    repeat (6) @(negedge clock);
                    expv = {m_toggles, 13'b0, sgmii_rx_p, sgmii_clk_p, sgmii_rx_p ^ sgmii_rx_n};
                end
                7:    begin o = 8'h03; expv = 32'h0; budget = 2000; is_mdio = 1'b1; end
                default: begin
                    o = 8'h04; phy_rdata = 16'($urandom);
                    expv = {16'h0, phy_rdata}; budget = 2000; is_mdio = 1'b1;
                end
            endcase
            run_op(o, a, v, budget, ok, lat, res, da);
            if (o == 8'h01) m_ctrl = v;
            tests_run++; if (!ok || res !== expv) begin fails++; $display("FAIL rand_%0d_op%h: got %h ok=%b, expected %h", n, o, res, ok, expv); end
            if (!is_mdio) begin
                tests_run++; if (lat !== 2 || da !== 1'b0) begin fails++; $display("FAIL rand_%0d_timing: latency %0d pulse-after %b, expected 2 and 0", n, lat, da); end
            end else if (o == 8'h03) begin
                tests_run++; if (got_frame() !== exp_frame(1'b0, a[9:5], a[4:0], v[15:0])) begin fails++; $display("FAIL rand_%0d_frame: got %h, expected %h", n, got_frame(), exp_frame(1'b0, a[9:5], a[4:0], v[15:0])); end
            end
            tests_run++; if (eth_reset_n !== m_ctrl[0]) begin fails++; $display("FAIL rand_%0d_phy_rst: got %b, expected %b", n, eth_reset_n, m_ctrl[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_ctrl();
        test_mdio_write();
        test_mdio_read();
        test_sgmii();
        test_error();
        test_ignored_start();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/driver_operation_engine.md
Name: driver_operation_engine

Overview:
- Single-clock command engine behind a start/done/return handshake. Executes one operation per start: control-register write/read, Clause-22 MDIO write/read to the Ethernet PHY, and SGMII line-status read.
- Sits between the host-side call interface and the PHY pins: SGMII pair, MDIO/MDC and PHY reset.

Parameters:
- MDC_HALF, 4, number of clock cycles per MDC half-period; MDC period is 2*MDC_HALF cycles.
- PREAMBLE_LEN, 32, number of MDIO preamble ones.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_port  in  1  start request; sampled only in IDLE.
- done_port  out  1  one-cycle completion pulse.
- return_port  out  32  result; valid while done_port=1 and held until the next start.
- operation  in  8  opcode; latched at start.
- address  in  32  operand address; latched at start.
- value  in  32  write data; latched at start.
- sgmii_tx_p, sgmii_tx_n  out  1 each  SGMII TX pair; static idle.
- sgmii_rx_p, sgmii_rx_n  in  1 each  SGMII RX pair.
- sgmii_clk_p, sgmii_clk_n  in  1 each  SGMII reference clock pair; sampled as data only.
- eth_mdio_i  in  1  MDIO input from the pad.
- eth_mdio_o  out  1  MDIO output to the pad.
- eth_mdio_t  out  1  MDIO tristate; 1 = released (input).
- eth_mdc  out  1  MDIO management clock.
- eth_reset_n  out  1  PHY reset, active low; equals ctrl[0].

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high; all flops clear immediately.
- Reset values: done_port=0, return_port=0, eth_mdc=0, eth_mdio_o=1, eth_mdio_t=1, eth_reset_n=0, sgmii_tx_p=0, sgmii_tx_n=1, ctrl=0, rx_toggle_cnt=0, FSM in IDLE.
- Reset mid-operation aborts the frame and releases MDIO.
- FSM states: IDLE, EXEC, MDIO_SHIFT, DONE.
  - IDLE & start_port=1: latch operation/address/value, go to EXEC.
  - EXEC, non-MDIO op: compute result, go to DONE.
  - EXEC, MDIO op: go to MDIO_SHIFT.
  - MDIO_SHIFT: go to DONE after the last bit.
  - DONE: done_port=1 for exactly one cycle, then IDLE.
  - start_port outside IDLE is ignored.
  - Register/status op latency: start sampled at edge N, done_port high in cycle N+2.
- Opcodes:
  - 0x00 NOP: return 0.
  - 0x01 CTRL_WR: ctrl <= value; return 0.
  - 0x02 CTRL_RD: return ctrl.
  - 0x03 MDIO_WR: PHY=address[9:5], REG=address[4:0], data=value[15:0]; return 0.
  - 0x04 MDIO_RD: same address fields; return {16'h0, rdata}.
  - 0x05 SGMII_STAT: return {rx_toggle_cnt[15:0], 13'b0, rx_p_sync, clk_p_sync, rx_valid}.
  - Any other opcode: return 32'hFFFF_FFFF.
- Address and value bits outside the fields above are ignored.
- MDIO frame, MSB first, one bit per MDC period:
  - PREAMBLE_LEN ones, ST=01, OP=01 (write) / 10 (read), PHYAD[4:0], REGAD[4:0].
  - Write: TA=10, then data[15:0].
  - Read: eth_mdio_t=1 from the TA bits through the end of data; data sampled from eth_mdio_i.
  - eth_mdio_o changes only right after MDC falls; eth_mdio_i sampled on the MDC rising transition.
  - Frame length is 64 MDC periods when PREAMBLE_LEN=32.
  - MDC toggles only in MDIO_SHIFT, otherwise stays 0. After the frame: eth_mdio_t=1, eth_mdio_o=1.
- SGMII:
  - TX held static idle (p=0, n=1).
  - rx_p and clk_p each pass through a 2-FF synchroniser.
  - rx_valid = synchronised (rx_p XOR rx_n).
  - rx_toggle_cnt increments on every change of rx_p_sync and wraps 16'hFFFF to 0.
  - SGMII status and counters are free-running, independent of the FSM.

Decomposition:
- Package driver_operation_pkg holds: the opcode localparams, the FSM state enum, MDIO ST/OP/TA constants and the ERR_RESULT constant (32'hFFFF_FFFF).
- One sub-module, mdio_master: takes start, is_read, phy, reg, wdata; produces rdata, busy, done and drives mdc/mdio_o/mdio_t. MDC_HALF and PREAMBLE_LEN are passed to it.

Test Plan:
- Reset: assert reset for 20 ns at time 0 -> all outputs at their reset values; eth_reset_n=0, eth_mdio_t=1.
- Control register: CTRL_WR value=0x1 -> return 0 and eth_reset_n=1; then CTRL_RD -> return 0x00000001. done_port is a single-cycle pulse arriving 2 cycles after start.
- MDIO write: MDIO_WR address=0x0021 (PHY1/REG1), value=0xABCD -> MDC frame of 64 periods. Captured bits: 32 ones, 01, 01, 00001, 00001, 10, 0xABCD. eth_mdio_t=0 for the whole frame. Return 0.
- MDIO read: MDIO_RD address=0x0022 with the model driving 0x1234 after TA -> eth_mdio_t=1 from TA onward; return 0x00001234.
- SGMII: drive rx_p/rx_n complementary and toggle rx_p 10 times -> SGMII_STAT return has [31:16]=10 and bit0=1. Drive rx_p=rx_n -> bit0=0.
- Errors and protocol: opcode 0x7F -> 0xFFFFFFFF. A start pulse during an MDIO frame is ignored (exactly one done). Reset mid-frame -> MDC stops immediately, MDIO released, and the next op runs correctly.
